// File: rtl/fp_mul_pkg.sv
`default_nettype none
//==============================================================================
// fp_mul_pkg : shared constants and stage types for the FP32 multiplier back end
// Rev 1.0
//==============================================================================
package fp_mul_pkg;

  localparam int          FP_BIAS       = 127;
  localparam logic [7:0]  EXP_INF       = 8'hFF;
  localparam logic [30:0] FP_MAX_FINITE = 31'h7F7FFFFF;
  localparam int          PROD_W        = 48;
  localparam int          FRAC_W        = 23;

  // Normalized product carried from stage 1 to stage 2
  typedef struct packed {
    logic              sign;
    logic              exception;
    logic [FRAC_W-1:0] mant;
    logic              g;
    logic              st;
    logic [9:0]        e;
  } norm_t;

endpackage
`default_nettype wire

// File: rtl/fp_mul_norm_round_if.sv
`default_nettype none
//==============================================================================
// fp_mul_norm_round_if : product-in / result-out handshake bundle
// Rev 1.0
//==============================================================================
interface fp_mul_norm_round_if;
  import fp_mul_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [8:0]        in_exp;
  logic [PROD_W-1:0] in_product;
  logic              in_exception;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       result;
  logic              overflow;
  logic              underflow;

  modport master (
    output in_valid, in_sign, in_exp, in_product, in_exception, out_ready,
    input  in_ready, out_valid, result, overflow, underflow
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_product, in_exception, out_ready,
    output in_ready, out_valid, result, overflow, underflow
  );

endinterface
`default_nettype wire

// File: rtl/fp_round_rne.sv
`default_nettype none
//==============================================================================
// fp_round_rne : combinational round-to-nearest-even of a 23-bit fraction
// Rev 1.0
//==============================================================================
module fp_round_rne
  import fp_mul_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic [FRAC_W-1:0] mant,
  input  logic              g,
  input  logic              st,
  input  logic [9:0]        e,
  output logic [FRAC_W-1:0] frac,
  output logic [9:0]        e_out,
  output logic              carry
);

  logic          w_rup;
  logic [FRAC_W:0] w_m24;

  always_comb begin
    w_rup = ROUND_EN && g && (st || mant[0]);
    w_m24 = {1'b0, mant} + {{FRAC_W{1'b0}}, w_rup};
    carry = w_m24[FRAC_W];
    // A carry out means the fraction was all ones: significand becomes 2.0
    frac  = carry ? '0 : w_m24[FRAC_W-1:0];
    e_out = e + {9'd0, carry};
  end

endmodule
`default_nettype wire

// File: rtl/fp_mul_norm_round.sv
`default_nettype none
//==============================================================================
// fp_mul_norm_round : two-stage normalize / round / pack back end of FP32 multiply
// Rev 1.0
//==============================================================================
module fp_mul_norm_round
  import fp_mul_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1,
  parameter bit SAT_EN   = 1'b0
) (
  input logic               clk,
  input logic               reset,
  fp_mul_norm_round_if.slave bus
);

  logic              w_adv;
  norm_t             w_norm;
  norm_t             r_s1;
  logic              r_s1_valid;
  logic [FRAC_W-1:0] w_frac;
  logic [9:0]        w_e_out;
  logic              w_carry;
  logic [31:0]       w_result;
  logic              w_ovf;
  logic              w_unf;
  logic              r_out_valid;
  logic [31:0]       r_result;
  logic              r_ovf;
  logic              r_unf;

  // Both stages move as one; a stalled output freezes the whole pipe
  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  always_comb begin
    w_norm           = '0;
    w_norm.sign      = bus.in_sign;
    w_norm.exception = bus.in_exception;
    if (bus.in_product[PROD_W-1]) begin
      w_norm.mant = bus.in_product[46:24];
      w_norm.g    = bus.in_product[23];
      w_norm.st   = |bus.in_product[22:0];
      w_norm.e    = {1'b0, bus.in_exp} + 10'd1;
    end else begin
      w_norm.mant = bus.in_product[45:23];
      w_norm.g    = bus.in_product[22];
      w_norm.st   = |bus.in_product[21:0];
      w_norm.e    = {1'b0, bus.in_exp};
    end
  end

  fp_round_rne #(.ROUND_EN(ROUND_EN)) u_round (
    .mant  (r_s1.mant),
    .g     (r_s1.g),
    .st    (r_s1.st),
    .e     (r_s1.e),
    .frac  (w_frac),
    .e_out (w_e_out),
    .carry (w_carry)
  );

  always_comb begin
    w_result = {r_s1.sign, w_e_out[7:0], w_frac};
    w_ovf    = 1'b0;
    w_unf    = 1'b0;
    if (r_s1.exception || w_e_out >= 10'd255) begin
      w_ovf    = 1'b1;
      w_result = SAT_EN ? {r_s1.sign, FP_MAX_FINITE}
                        : {r_s1.sign, EXP_INF, {FRAC_W{1'b0}}};
    end else if (r_s1.e == 10'd0 && !w_carry) begin
      // No denormal support: flush to signed zero
      w_unf    = 1'b1;
      w_result = {r_s1.sign, 31'h0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid  <= 1'b0;
      r_s1        <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid  <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1 <= w_norm;
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_result;
        r_ovf    <= w_ovf;
        r_unf    <= w_unf;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_norm_round.sv
`default_nettype none
//==============================================================================
// tb_fp_mul_norm_round : directed vectors on default and truncate/saturate builds
// Rev 1.0
//==============================================================================
module tb_fp_mul_norm_round;

  typedef struct {
    logic        sign;
    logic [8:0]  exp;
    logic [47:0] prod;
    logic        exc;
    logic [31:0] res_a;
    logic        ovf_a;
    logic        unf_a;
    logic [31:0] res_b;
    logic        ovf_b;
    logic        unf_b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_mul_norm_round_if bus_a ();
  fp_mul_norm_round_if bus_b ();

  fp_mul_norm_round dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_a)
  );

  fp_mul_norm_round #(.ROUND_EN(1'b0), .SAT_EN(1'b1)) dut_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_b)
  );

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[13];
  int   bp_idx[4];

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s idx=%0d actual=%h required=%h", nm, idx, act, req);
    end
  endtask

  task automatic drive(input logic v, input vec_t t);
    bus_a.in_valid     = v;
    bus_a.in_sign      = t.sign;
    bus_a.in_exp       = t.exp;
    bus_a.in_product   = t.prod;
    bus_a.in_exception = t.exc;
    bus_b.in_valid     = v;
    bus_b.in_sign      = t.sign;
    bus_b.in_exp       = t.exp;
    bus_b.in_product   = t.prod;
    bus_b.in_exception = t.exc;
  endtask

  task automatic set_ready(input logic r);
    bus_a.out_ready = r;
    bus_b.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one item, waits for it, checks latency and both builds' outputs
  task automatic send_one(input int i, input vec_t t);
    int lat;
    drive(1'b1, t);
    #1;
    chk("in_ready", i, {31'd0, bus_a.in_ready}, 32'd1);
    tick();
    drive(1'b0, t);
    lat = 1;
    while (!bus_a.out_valid && lat < 8) begin
      tick();
      lat++;
    end
    chk("latency",  i, lat, 32'd2);
    chk("res_a",    i, bus_a.result, t.res_a);
    chk("ovf_a",    i, {31'd0, bus_a.overflow},  {31'd0, t.ovf_a});
    chk("unf_a",    i, {31'd0, bus_a.underflow}, {31'd0, t.unf_a});
    chk("valid_b",  i, {31'd0, bus_b.out_valid}, 32'd1);
    chk("res_b",    i, bus_b.result, t.res_b);
    chk("ovf_b",    i, {31'd0, bus_b.overflow},  {31'd0, t.ovf_b});
    chk("unf_b",    i, {31'd0, bus_b.underflow}, {31'd0, t.unf_b});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog idx=0 actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, stall, cyc;

    //          sign exp  product          exc  res_a         ovf unf  res_b         ovf unf
    vecs[0]  = '{1'b0, 9'd127, 48'h400000000000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 9'd127, 48'h900000000000, 1'b0, 32'h40100000, 1'b0, 1'b0, 32'h40100000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 9'd127, 48'h7FFFFFC00000, 1'b0, 32'h40000000, 1'b0, 1'b0, 32'h3FFFFFFF, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 9'd254, 48'h800000000000, 1'b0, 32'hFF800000, 1'b1, 1'b0, 32'hFF7FFFFF, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 9'd0,   48'h400000000000, 1'b0, 32'h80000000, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 9'd127, 48'h400000000000, 1'b1, 32'h7F800000, 1'b1, 1'b0, 32'h7F7FFFFF, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 9'd254, 48'h7FFFFFC00000, 1'b0, 32'h7F800000, 1'b1, 1'b0, 32'h7F7FFFFF, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 9'd0,   48'h800000000000, 1'b0, 32'h00800000, 1'b0, 1'b0, 32'h00800000, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 9'd300, 48'h400000000000, 1'b0, 32'hFF800000, 1'b1, 1'b0, 32'hFF7FFFFF, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 9'd127, 48'h400000400000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 9'd127, 48'h400000C00000, 1'b0, 32'h3F800002, 1'b0, 1'b0, 32'h3F800001, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 9'd127, 48'h400000400001, 1'b0, 32'h3F800001, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 9'd130, 48'hC00000000000, 1'b0, 32'hC1C00000, 1'b0, 1'b0, 32'hC1C00000, 1'b0, 1'b0};
    bp_idx   = '{1, 2, 10, 12};

    rst_n = 1'b0;
    drive(1'b0, vecs[0]);
    set_ready(1'b1);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", 0, {31'd0, bus_a.out_valid}, 32'd0);
    chk("rst_result", 0, bus_a.result, 32'd0);
    chk("rst_ovf", 0, {31'd0, bus_a.overflow}, 32'd0);
    chk("rst_unf", 0, {31'd0, bus_a.underflow}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 0, {31'd0, bus_a.in_ready}, 32'd1);
    tick();

    for (int i = 0; i < 13; i++) begin
      send_one(i, vecs[i]);
    end
    tick();
    tick();

    // Back-to-back stream with a stall after the first result
    sent = 0; got = 0; stall = 0; cyc = 0;
    while (got < 4 && cyc < 60) begin
      if (sent < 4) drive(1'b1, vecs[bp_idx[sent]]);
      else          drive(1'b0, vecs[0]);
      set_ready(!(got >= 1 && stall < 6));
      #1;
      if (!bus_a.out_ready) begin
        stall++;
        chk("bp_in_ready", got, {31'd0, bus_a.in_ready}, 32'd0);
        chk("bp_hold_valid", got, {31'd0, bus_a.out_valid}, 32'd1);
        chk("bp_hold_result", got, bus_a.result, vecs[bp_idx[got]].res_a);
      end
      if (bus_a.out_valid && bus_a.out_ready) begin
        chk("bp_result", got, bus_a.result, vecs[bp_idx[got]].res_a);
        chk("bp_res_b", got, bus_b.result, vecs[bp_idx[got]].res_b);
        got++;
      end
      if (bus_a.in_valid && bus_a.in_ready) sent++;
      tick();
      cyc++;
    end
    chk("bp_count", 0, got, 32'd4);
    drive(1'b0, vecs[0]);
    set_ready(1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_no_dup", k, {31'd0, bus_a.out_valid}, 32'd0);
      tick();
    end

    // Reset with two items in flight
    set_ready(1'b0);
    drive(1'b1, vecs[1]);
    tick();
    drive(1'b1, vecs[2]);
    tick();
    drive(1'b0, vecs[0]);
    #1;
    chk("inflight_valid", 0, {31'd0, bus_a.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid_a", 0, {31'd0, bus_a.out_valid}, 32'd0);
    chk("async_rst_valid_b", 0, {31'd0, bus_b.out_valid}, 32'd0);
    chk("async_rst_result", 0, bus_a.result, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 0, {31'd0, bus_a.in_ready}, 32'd1);
    set_ready(1'b1);
    tick();
    send_one(12, vecs[12]);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_mul_norm_round.md
Name: fp_mul_norm_round

Overview:
- Back end of the vector FP32 multiplier. Consumes the raw multiplier-core output: sign, 9-bit biased exponent, 48-bit mantissa product and exception flag.
- Normalizes, rounds to nearest-even and packs an IEEE-754 single-precision result with overflow/underflow flags.
- Two-stage pipeline with valid/ready handshakes on both sides.
- Sits between the multiplier core and the lane result register.

Parameters:
- ROUND_EN, 1, 1 = round-to-nearest-even; 0 = truncate (guard/sticky ignored).
- SAT_EN, 0, 1 = overflow yields max finite 0x7F7FFFFF (sign applied); 0 = infinity.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream product valid
- in_ready  output  1  block can accept this cycle
- in_sign  input  1  product sign
- in_exp  input  9  biased exponent sum (e_a+e_b-127), unsigned; 256..511 means overflow
- in_product  input  48  {1.m_a}*{1.m_b}, fixed point 2.46
- in_exception  input  1  upstream exponent out of range
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- result  output  32  packed FP32 {sign, exp[7:0], frac[22:0]}
- overflow  output  1  result overflowed (inf or saturated)
- underflow  output  1  result flushed to zero

Behaviour:
- Reset (async, reset=0):
  - S1/S2 valid cleared.
  - out_valid=0, result=0, overflow=0, underflow=0.
  - in_ready=1 once reset is released.
  - Reset mid-operation discards in-flight data; no partial output.
- Handshake:
  - adv = !out_valid | out_ready; in_ready = adv (combinational).
  - A transfer occurs when in_valid & in_ready; out transfer when out_valid & out_ready.
  - Both stages advance together on adv. When adv=0, all stage registers hold and in_ready=0.
  - Outputs stay stable while out_valid & !out_ready.
  - Simultaneous in and out transfers are allowed: full throughput, 1 result/cycle.
- Latency: accepted input appears on out_valid exactly 2 cycles later when not stalled.
- Stage 1 (normalize):
  - If product[47]=1: mant=product[46:24], g=product[23], st=|product[22:0], e=in_exp+1.
  - Else: mant=product[45:23], g=product[22], st=|product[21:0], e=in_exp.
  - e is 10 bits wide (max 512).
  - Register sign, exception, mant, g, st, e.
- Stage 2 (round/pack):
  - rup = ROUND_EN & g & (st | mant[0]).
  - m24 = {1'b0, mant} + rup. If m24[23] (carry): frac=0, e=e+1. Else frac=m24[22:0].
  - Priority, highest first:
    1. exception=1 → result={sign,8'hFF,23'h0} (SAT_EN: {sign,31'h7F7FFFFF}), overflow=1.
    2. e>=255 → same as exception, overflow=1.
    3. e==0 → result={sign,31'h0}, underflow=1 (flush-to-zero, no denormals).
    4. Otherwise result={sign,e[7:0],frac}, flags 0.
- Flags are valid only with out_valid; they are cleared on the next accepted transfer that does not set them.
- Boundary cases:
  - e=254 with rounding carry → 255 → overflow.
  - in_exp=0 with product[47]=1 → e=1, normal result.

Decomposition:
- Package fp_mul_pkg:
  - constants: FP_BIAS=127, EXP_INF=8'hFF, FP_MAX_FINITE=31'h7F7FFFFF, PROD_W=48, FRAC_W=23.
  - typedef norm_t {sign, exception, mant[22:0], g, st, e[9:0]} for the S1→S2 register.
- Sub-module fp_round_rne: combinational, mant/g/st/e in → frac/e_out/carry out. Reused by future adder back end.

Test Plan:
- 1.0*1.0: in_exp=127, product=0x400000000000 → result=0x3F800000, flags 0, out_valid 2 cycles after accept.
- 1.5*1.5: in_exp=127, product=0x900000000000 → result=0x40100000 (2.25).
- Round carry: in_exp=127, product=0x7FFFFFC00000 → result=0x40000000. With ROUND_EN=0 → 0x3FFFFFFF.
- Overflow/underflow:
  - in_exp=254, product[47]=1, sign=1 → 0xFF800000, overflow=1 (SAT_EN=1: 0xFF7FFFFF).
  - in_exp=0, product[47]=0 → 0x00000000, underflow=1.
  - in_exception=1 → inf, overflow=1.
- Backpressure: send 4 back-to-back with out_ready=0 after the 1st output → in_ready drops and outputs hold. Release → all 4 results delivered in order, no loss or duplication.
- Assert reset with 2 items in flight → out_valid=0 immediately. After release, the first new input yields the first output 2 cycles later.
